mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 22 ++
 rtl/mem_responder_if.sv | 14 +
 rtl/mem_responder_mem_array.sv | 26 ++
 rtl/mem_responder.sv | 101 ++++++++++
 tb/tb_mem_responder.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared FSM encoding, defaults and address check for the memory responder
package mem_responder_pkg;

    localparam int DEFAULT_DEPTH       = 256;
    localparam int DEFAULT_WAIT_CYCLES = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    // Misaligned or beyond the last word: completes with err and touches nothing.
    function automatic logic addr_bad(input logic [31:0] addr, input int depth);
        return (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(depth));
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bus between a controller and the memory responder
interface mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (output req, we, addr, wdata, input rdata, ready, err, busy);
    modport slave  (input req, we, addr, wdata, output rdata, ready, err, busy);
endinterface

// File: rtl/mem_responder_mem_array.sv
// rtl/mem_responder_mem_array.sv - word storage, synchronous write and combinational read, never cleared
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state memory responder: latches a request, waits, then pulses ready
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    txn_t        txn_q, txn_d;
    logic        bad_q, bad_d;
    logic [31:0] rdata_q, rdata_d;

    txn_t        cur;
    logic        cur_bad;
    logic [31:0] arr_rdata;
    logic        arr_we;

    // In IDLE the live bus is the transaction; afterwards only the latched copy counts.
    always_comb begin
        cur = txn_q;
        if (state_q == ST_IDLE) begin
            cur.we    = bus.we;
            cur.addr  = bus.addr;
            cur.wdata = bus.wdata;
        end
    end

    assign cur_bad = addr_bad(cur.addr, DEPTH);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        txn_d   = txn_q;
        bad_d   = bad_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    txn_d   = cur;
                    bad_d   = cur_bad;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Read data is captured on entry to RESP so it is valid for the whole ready cycle.
        if ((state_d == ST_RESP) && (state_q != ST_RESP) && !cur.we) begin
            rdata_d = cur_bad ? 32'd0 : arr_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            txn_q   <= '0;
            bad_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            txn_q   <= txn_d;
            bad_q   <= bad_d;
            rdata_q <= rdata_d;
        end
    end

    assign arr_we = (state_q == ST_RESP) && txn_q.we && !bad_q;

    mem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .waddr_i (txn_q.addr[AW+1:2]),
        .wdata_i (txn_q.wdata),
        .raddr_i (cur.addr[AW+1:2]),
        .rdata_o (arr_rdata)
    );

    assign bus.ready = (state_q == ST_RESP);
    assign bus.err   = (state_q == ST_RESP) && bad_q;
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder with a response scoreboard
module tb_mem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    exp_t        sb_a[$];
    exp_t        sb_b[$];
    logic [31:0] mm[int];
    logic [31:0] last_rd;

    mem_responder_if bus_a();
    mem_responder_if bus_b();

    mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut_a (
        .clk (clk),
        .rst (rst_n),
        .bus (bus_a)
    );

    mem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dut_b (
        .clk (clk),
        .rst (rst_n),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input string name);
        int   n;
        int   g;
        logic got;
        logic bad;
        exp_t e;
        g = 0;
        @(negedge clk);
        while (bus_a.busy && g < 20) begin
            @(negedge clk);
            g++;
        end
        bad = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd256);
        if (!we) last_rd = bad ? 32'd0 : mm[int'(addr[31:2])];
        else if (!bad) mm[int'(addr[31:2])] = wdata;
        sb_a.push_back('{rdata: last_rd, err: bad});
        bus_a.req = 1'b1; bus_a.we = we; bus_a.addr = addr; bus_a.wdata = wdata;
        n = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(posedge clk);
            #1;
            n++;
            bus_a.req = 1'b0;
            got = bus_a.ready;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout: no ready after %0d cycles", name, n);
            void'(sb_a.pop_front());
            return;
        end
        e = sb_a.pop_front();
        checks += 3;
        if (n !== 3) begin
            errors++;
            $display("FAIL %s_latency: got %0d required 3", name, n);
        end
        if (bus_a.rdata !== e.rdata) begin
            errors++;
            $display("FAIL %s_rdata: got %h required %h", name, bus_a.rdata, e.rdata);
        end
        if (bus_a.err !== e.err) begin
            errors++;
            $display("FAIL %s_err: got %b required %b", name, bus_a.err, e.err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus_a.ready !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.err !== 1'b0) begin
            errors++;
            $display("FAIL %s_after: ready=%b busy=%b err=%b required 0 0 0",
                     name, bus_a.ready, bus_a.busy, bus_a.err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_a.busy, bus_a.ready, bus_a.err, bus_a.rdata,
             bus_b.busy, bus_b.ready, bus_b.err, bus_b.rdata} !== 70'd0) begin
            errors++;
            $display("FAIL reset_outputs: a=%b%b%b/%h b=%b%b%b/%h required all zero",
                     bus_a.busy, bus_a.ready, bus_a.err, bus_a.rdata,
                     bus_b.busy, bus_b.ready, bus_b.err, bus_b.rdata);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_rd = 32'd0;
    endtask

    task automatic test_write_read();
        run_txn(1'b1, 32'h10, 32'hDEADBEEF, "wr10");
        run_txn(1'b0, 32'h10, 32'h0, "rd10");
        run_txn(1'b1, 32'h30, 32'hA5A5A5A5, "wr30");
        run_txn(1'b0, 32'h30, 32'h0, "rd30_raw");
        run_txn(1'b1, 32'h30, 32'h5A5A5A5A, "wr30_hold");
        run_txn(1'b0, 32'h30, 32'h0, "rd30_new");
    endtask

    task automatic test_misaligned();
        run_txn(1'b0, 32'h13, 32'h0, "rd13");
        run_txn(1'b1, 32'h11, 32'hFFFF0000, "wr11");
        run_txn(1'b0, 32'h10, 32'h0, "rd10_again");
    endtask

    task automatic test_out_of_range();
        run_txn(1'b1, 32'h0, 32'h11111111, "wr0");
        run_txn(1'b1, 32'h3FC, 32'h22222222, "wr3fc");
        run_txn(1'b1, 32'h400, 32'hBADBADBA, "wr400");
        run_txn(1'b0, 32'h0, 32'h0, "rd0");
        run_txn(1'b0, 32'h3FC, 32'h0, "rd3fc");
        run_txn(1'b0, 32'h400, 32'h0, "rd400");
    endtask

    task automatic test_ignore_busy();
        int pulses;
        @(negedge clk);
        bus_a.req = 1'b1; bus_a.we = 1'b0; bus_a.addr = 32'h10;
        @(posedge clk);
        #1;
        bus_a.req = 1'b0; bus_a.we = 1'b1; bus_a.addr = 32'h20; bus_a.wdata = 32'hFEEDFACE;
        @(negedge clk);
        bus_a.req = 1'b1; bus_a.addr = 32'h3FC;
        @(negedge clk);
        bus_a.req = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus_a.ready) begin
                pulses++;
                checks++;
                if (bus_a.rdata !== 32'hDEADBEEF || bus_a.err !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_latched: rdata=%h err=%b required deadbeef 0",
                             bus_a.rdata, bus_a.err);
                end
            end
        end
        last_rd = 32'hDEADBEEF;
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL busy_pulses: got %0d required 1", pulses);
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        run_txn(1'b1, 32'h20, 32'h12345678, "wr20");
        @(negedge clk);
        bus_a.req = 1'b1; bus_a.we = 1'b1; bus_a.addr = 32'h20; bus_a.wdata = 32'hBAD0BAD0;
        @(posedge clk);
        #1;
        bus_a.req = 1'b0;
        checks++;
        if (bus_a.busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_accept: busy=%b required 1", bus_a.busy);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_a.busy !== 1'b0 || bus_a.ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: busy=%b ready=%b required 0 0", bus_a.busy, bus_a.ready);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                @(negedge clk);
                rst_n = 1'b1;
            end
            @(posedge clk);
            #1;
            if (bus_a.ready) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort_ready: got %0d pulses required 0", pulses);
        end
        last_rd = 32'd0;
        run_txn(1'b0, 32'h20, 32'h0, "rd20_old");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_b.req = 1'b1; bus_b.we = 1'b1;
            bus_b.addr = 32'(4 * i); bus_b.wdata = 32'hC0DE0000 + 32'(i);
            @(posedge clk);
            #1;
            bus_b.req = 1'b0;
            checks++;
            if (bus_b.ready !== 1'b1 || bus_b.err !== 1'b0) begin
                errors++;
                $display("FAIL b2b_wr%0d: ready=%b err=%b required 1 0", i, bus_b.ready, bus_b.err);
            end
            @(posedge clk);
        end
        for (int i = 0; i < 3; i++) sb_b.push_back('{rdata: 32'hC0DE0000 + 32'(i), err: 1'b0});
        @(negedge clk);
        bus_b.req = 1'b1; bus_b.we = 1'b0; bus_b.addr = 32'h0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus_b.ready !== ((c % 2) == 0)) begin
                errors++;
                $display("FAIL b2b_pattern_c%0d: ready=%b required %b", c, bus_b.ready, (c % 2) == 0);
            end
            if (bus_b.ready && sb_b.size() > 0) begin
                e = sb_b.pop_front();
                checks++;
                if (bus_b.rdata !== e.rdata || bus_b.err !== e.err) begin
                    errors++;
                    $display("FAIL b2b_rd_c%0d: rdata=%h err=%b required %h %b",
                             c, bus_b.rdata, bus_b.err, e.rdata, e.err);
                end
                bus_b.addr = 32'(4 * (c / 2 + 1));
                if (c >= 4) bus_b.req = 1'b0;
            end
        end
        checks++;
        if (sb_b.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d responses missing required 0", sb_b.size());
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        last_rd = 32'd0;
        rst_n   = 1'b1;
        bus_a.req = 1'b0; bus_a.we = 1'b0; bus_a.addr = '0; bus_a.wdata = '0;
        bus_b.req = 1'b0; bus_b.we = 1'b0; bus_b.addr = '0; bus_b.wdata = '0;
        test_reset();
        test_write_read();
        test_misaligned();
        test_out_of_range();
        test_ignore_busy();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
